// File: rtl/fixed_to_bcd_pkg.sv
// Shared types and constants for the fixed-point to BCD display converter.
package fixed_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int BCD_W          = 4;
    localparam int DEFAULT_INT_W  = 2;
    localparam int DEFAULT_FRAC_W = 16;

endpackage

// File: rtl/frac_mul10.sv
// One multiply-by-10 step: the carry out of the fraction is the next decimal digit.
module frac_mul10
    import fixed_to_bcd_pkg::*;
#(
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic [FRAC_W-1:0] f,
    output logic [BCD_W-1:0]  digit,
    output logic [FRAC_W-1:0] f_next
);

    logic [FRAC_W+3:0] f_ext;
    logic [FRAC_W+3:0] p;

    // 10*F as 8*F + 2*F; F < 2^FRAC_W keeps the top nibble in 0..9
    always_comb begin
        f_ext  = {4'b0000, f};
        p      = (f_ext << 3) + (f_ext << 1);
        digit  = p[FRAC_W+3:FRAC_W];
        f_next = p[FRAC_W-1:0];
    end

endmodule

// File: rtl/fixed_to_bcd.sv
// Captures a 2.16 fixed-point result and converts it to BCD digits for the display.
module fixed_to_bcd
    import fixed_to_bcd_pkg::*;
#(
    parameter int INT_W       = DEFAULT_INT_W,
    parameter int FRAC_W      = DEFAULT_FRAC_W,
    parameter int FRAC_DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_in,
    input  logic [INT_W-1:0]             intpart,
    input  logic [FRAC_W-1:0]            fracpart,
    output logic                         busy,
    output logic                         valid,
    output logic [BCD_W-1:0]             int_digit,
    output logic [BCD_W*FRAC_DIGITS-1:0] frac_digits,
    output logic                         overrun
);

    localparam int CNT_W  = $clog2(FRAC_DIGITS + 1);
    localparam int WORK_W = BCD_W * FRAC_DIGITS;

    state_t state;
    state_t next_state;

    logic [INT_W-1:0]        int_r;
    logic [FRAC_W-1:0]       f_r;
    logic [FRAC_W-1:0]       f_next;
    logic [BCD_W-1:0]        digit;
    logic [CNT_W-1:0]        cnt;
    logic [WORK_W-1:0]       work;
    logic [WORK_W-1:0]       work_next;
    logic [WORK_W+BCD_W-1:0] shifted;

    logic capture;
    logic step;
    logic last_step;
    logic overrun_set;

    frac_mul10 #(
        .FRAC_W (FRAC_W)
    ) u_mul10 (
        .f      (f_r),
        .digit  (digit),
        .f_next (f_next)
    );

    always_comb begin
        shifted   = {work, digit};
        work_next = shifted[WORK_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        step        = 1'b0;
        last_step   = (cnt == CNT_W'(FRAC_DIGITS - 1));
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (done_in) begin
                    capture    = 1'b1;
                    next_state = CONV;
                end
            end
            CONV: begin
                step        = 1'b1;
                overrun_set = done_in;
                if (last_step) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                if (done_in) begin
                    capture    = 1'b1;
                    next_state = CONV;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Display registers load on the final step edge so they are visible alongside valid in OUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_r       <= '0;
            f_r         <= '0;
            cnt         <= '0;
            work        <= '0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            int_digit   <= '0;
            frac_digits <= '0;
        end else begin
            busy  <= (next_state != IDLE);
            valid <= (next_state == OUT);
            if (capture) begin
                int_r   <= intpart;
                f_r     <= fracpart;
                cnt     <= '0;
                work    <= '0;
                overrun <= 1'b0;
            end else begin
                if (overrun_set) begin
                    overrun <= 1'b1;
                end
                if (step) begin
                    f_r  <= f_next;
                    cnt  <= cnt + CNT_W'(1);
                    work <= work_next;
                    if (last_step) begin
                        frac_digits <= work_next;
                        int_digit   <= {{(BCD_W-INT_W){1'b0}}, int_r};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_bcd.sv
// Directed self-checking bench for fixed_to_bcd with hand-computed digit vectors.
module tb_fixed_to_bcd;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic        busy;
    logic        valid;
    logic [3:0]  int_digit;
    logic [15:0] frac_digits;
    logic        overrun;

    int assertCount = 0;
    int failCount   = 0;
    int lat;
    int busyLow;
    int validSeen;

    fixed_to_bcd dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .intpart     (intpart),
        .fracpart    (fracpart),
        .busy        (busy),
        .valid       (valid),
        .int_digit   (int_digit),
        .frac_digits (frac_digits),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge
    task automatic applyStimulus(input logic [1:0] ip, input logic [15:0] fp);
        intpart  = ip;
        fracpart = fp;
        done_in  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_in = 1'b0;
    endtask

    task automatic waitValid(output int cycles, output int lowBusy);
        cycles  = 0;
        lowBusy = 0;
        while (!valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (!busy) lowBusy++;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, "_valid"}, {31'b0, valid}, 32'h0);
        checkOutput({tag, "_ovr"}, {31'b0, overrun}, 32'h0);
        checkOutput({tag, "_int"}, {28'b0, int_digit}, 32'h0);
        checkOutput({tag, "_frac"}, {16'b0, frac_digits}, 32'h0);
    endtask

    task automatic runVector(input string tag, input logic [1:0] ip, input logic [15:0] fp,
                             input logic [3:0] expInt, input logic [15:0] expFrac);
        applyStimulus(ip, fp);
        checkOutput({tag, "_busy_rise"}, {31'b0, busy}, 32'h1);
        waitValid(lat, busyLow);
        checkOutput({tag, "_latency"}, lat, 32'd4);
        checkOutput({tag, "_int"}, {28'b0, int_digit}, {28'b0, expInt});
        checkOutput({tag, "_frac"}, {16'b0, frac_digits}, {16'b0, expFrac});
        @(negedge clk);
        checkOutput({tag, "_valid_drop"}, {31'b0, valid}, 32'h0);
        checkOutput({tag, "_busy_drop"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, "_hold"}, {16'b0, frac_digits}, {16'b0, expFrac});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        done_in  = 1'b0;
        intpart  = '0;
        fracpart = '0;
        #12;
        checkAllZero("por");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        runVector("half", 2'd1, 16'h8000, 4'd1, 16'h5000);

        // Asynchronous reset between edges must clear held outputs immediately
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkAllZero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        runVector("e", 2'd2, 16'hB7E1, 4'd2, 16'h7182);
        runVector("max", 2'd3, 16'hFFFF, 4'd3, 16'h9999);

        // Dropped pulse during CONV sets overrun
        applyStimulus(2'd0, 16'h4000);
        @(negedge clk);
        intpart  = 2'd0;
        fracpart = 16'hC000;
        done_in  = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        checkOutput("ovr_set", {31'b0, overrun}, 32'h1);
        waitValid(lat, busyLow);
        checkOutput("ovr_valid", {31'b0, valid}, 32'h1);
        checkOutput("ovr_frac", {16'b0, frac_digits}, 32'h2500);
        checkOutput("ovr_sticky", {31'b0, overrun}, 32'h1);

        // Back-to-back capture in the OUT cycle
        applyStimulus(2'd0, 16'hC000);
        checkOutput("b2b_ovr_clr", {31'b0, overrun}, 32'h0);
        checkOutput("b2b_busy", {31'b0, busy}, 32'h1);
        checkOutput("b2b_valid_drop", {31'b0, valid}, 32'h0);
        waitValid(lat, busyLow);
        checkOutput("b2b_latency", lat, 32'd4);
        checkOutput("b2b_busy_hold", busyLow, 32'd0);
        checkOutput("b2b_frac", {16'b0, frac_digits}, 32'h7500);
        checkOutput("b2b_int", {28'b0, int_digit}, 32'h0);
        @(negedge clk);

        // Reset two cycles into CONV discards the conversion
        applyStimulus(2'd3, 16'hFFFF);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 checkAllZero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid) validSeen++;
        end
        checkOutput("mid_rst_no_valid", validSeen, 32'd0);
        checkAllZero("mid_rst_after");

        runVector("post_rst", 2'd2, 16'hB7E1, 4'd2, 16'h7182);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
